// File: rtl/pong_game_ctrl.sv
// Pong game sequencer and score keeper: IDLE -> SERVE -> PLAY -> OVER, with miss detection and scoring.
// Optional build macro PONG_CTRL_DEUCE_EN: a win needs a 2-point lead, or the maximum counter value.
module pong_game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50,
  parameter int SCORE_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic [9:0]         i_ball_x,
  input  logic [5:0]         i_ball_width,
  input  logic [5:0]         i_wall_width,
  output logic               o_play_en,
  output logic               o_serve,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_score_l,
  output logic [SCORE_W-1:0] o_score_r,
  output logic [1:0]         o_state,
  output logic               o_winner
);
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [CNT_W-1:0]   DLY_LOAD  = CNT_W'(SERVE_DELAY);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0] r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  logic               r_serve_dir, w_serve_dir_nxt;
  logic               r_winner, w_winner_nxt;
  logic               r_play_en, r_serve;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  function automatic logic win_chk(input logic [SCORE_W-1:0] nw, input logic [SCORE_W-1:0] opp);
`ifdef PONG_CTRL_DEUCE_EN
    return (nw == SCORE_MAX) ||
           ((nw >= SCORE_W'(WIN_SCORE)) && ({1'b0, nw} >= ({1'b0, opp} + 2'd2)));
`else
    return nw >= SCORE_W'(WIN_SCORE);
`endif
  endfunction

  // Miss tests in 11 bits so ball_x + ball_width cannot overflow
  logic [10:0] w_ball_r, w_rlimit;
  logic        w_lmiss, w_rmiss;
  logic [SCORE_W-1:0] w_sl_inc, w_sr_inc;
  assign w_ball_r = {1'b0, i_ball_x} + {5'b0, i_ball_width};
  assign w_rlimit = 11'(SCREEN_W) - {5'b0, i_wall_width};
  assign w_lmiss  = {1'b0, i_ball_x} < {5'b0, i_wall_width};
  assign w_rmiss  = w_ball_r > w_rlimit;
  assign w_sl_inc = sat_inc(r_score_l);
  assign w_sr_inc = sat_inc(r_score_r);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nxt = S_SERVE;
        w_cnt_nxt   = DLY_LOAD;
      end
      S_SERVE: if (i_tick) begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_PLAY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_PLAY: if (i_tick) begin
        // Left miss takes priority when both walls are hit on one tick
        if (w_lmiss) begin
          w_score_r_nxt   = w_sr_inc;
          w_serve_dir_nxt = 1'b0;
          if (win_chk(w_sr_inc, r_score_l)) begin
            w_state_nxt  = S_OVER;
            w_winner_nxt = 1'b0;
          end else begin
            w_state_nxt = S_SERVE;
            w_cnt_nxt   = DLY_LOAD;
          end
        end else if (w_rmiss) begin
          w_score_l_nxt   = w_sl_inc;
          w_serve_dir_nxt = 1'b1;
          if (win_chk(w_sl_inc, r_score_r)) begin
            w_state_nxt  = S_OVER;
            w_winner_nxt = 1'b1;
          end else begin
            w_state_nxt = S_SERVE;
            w_cnt_nxt   = DLY_LOAD;
          end
        end
      end
      S_OVER: if (i_start) begin
        w_score_l_nxt   = '0;
        w_score_r_nxt   = '0;
        w_serve_dir_nxt = 1'b1;
        w_state_nxt     = S_SERVE;
        w_cnt_nxt       = DLY_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_serve_dir <= 1'b1;
      r_winner    <= 1'b0;
      r_play_en   <= 1'b0;
      r_serve     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_winner    <= w_winner_nxt;
      // Decoded from next state so both flags line up with o_state
      r_play_en   <= (w_state_nxt == S_PLAY);
      r_serve     <= (w_state_nxt == S_SERVE) && (r_state != S_SERVE);
    end
  end

  assign o_state     = r_state;
  assign o_play_en   = r_play_en;
  assign o_serve     = r_serve;
  assign o_serve_dir = r_serve_dir;
  assign o_score_l   = r_score_l;
  assign o_score_r   = r_score_r;
  assign o_winner    = r_winner;
endmodule
